// File: rtl/fxp_alu_seq.sv
// fxp_alu_seq: multi-cycle signed fixed-point ALU, one op in flight.
// Define FXP_SAT_EN to saturate overflowed results instead of wrapping.
module fxp_alu_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div0
);

  localparam int XW = 2*WIDTH+1;
  localparam int DW = WIDTH+FRAC;
  localparam int CW = $clog2(DW+1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state;

  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH:0]     mb;
  logic [DW-1:0]      qd;
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH:0]     sa, sb, abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [DW-1:0]      qd_nx;
  logic [XW-1:0]      mag;
  logic signed [XW-1:0] sv, tv, xa, xb;
  logic               fits, dz, is_mul, is_div, fin, ovf_c;
  logic [WIDTH-1:0]   res_c;

  always_comb begin
    sa = {a[WIDTH-1], a};
    sb = {b[WIDTH-1], b};
    abs_a = a[WIDTH-1] ? ~sa + 1'b1 : sa;
    abs_b = b[WIDTH-1] ? ~sb + 1'b1 : sb;
    xa = XW'($signed(a));
    xb = XW'($signed(b));

    prod_nx = prod + (mb[0] ? mcand : '0);
    // Restoring step: remainder stays below |b|, so WIDTH bits suffice
    rem_sh = {rem, qd[DW-1]};
    ge = rem_sh >= mb;
    rem_nx = WIDTH'(ge ? rem_sh - mb : rem_sh);
    qd_nx = {qd[DW-2:0], ge};

    mag = (state == DIV) ? XW'(qd_nx) : XW'(prod_nx);
    sv = neg ? -$signed(mag) : $signed(mag);

    tv = '0;
    unique case (1'b1)
      state == MUL: tv = sv >>> FRAC;
      state == DIV: tv = sv;
      default: begin
        unique case (op)
          3'b000:  tv = xa + xb;
          3'b001:  tv = xa - xb;
          3'b100:  tv = XW'($signed(a & b));
          3'b101:  tv = XW'($signed(a | b));
          3'b110:  tv = XW'($signed(a ^ b));
          3'b111:  tv = xa;
          default: tv = '0;
        endcase
      end
    endcase

    fits = (&tv[XW-1:WIDTH-1]) | ~(|tv[XW-1:WIDTH-1]);
`ifdef FXP_SAT_EN
    res_c = fits ? tv[WIDTH-1:0] : (tv[XW-1] ? MINV : MAXV);
`else
    res_c = tv[WIDTH-1:0];
`endif
    dz = (state == IDLE) && (op == 3'b011) && (b == '0);
    ovf_c = !fits && !dz;
    if (dz) res_c = a[WIDTH-1] ? MINV : MAXV;

    is_mul = (op == 3'b010);
    is_div = (op == 3'b011) && !dz;
    fin = ((state == IDLE) && in_valid && in_ready && !is_mul && !is_div)
       || ((state == MUL) && (cnt == CW'(WIDTH-1)))
       || ((state == DIV) && (cnt == CW'(DW-1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mb        <= '0;
      qd        <= '0;
      rem       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid && in_ready) begin
          neg      <= a[WIDTH-1] ^ b[WIDTH-1];
          mb       <= abs_b;
          cnt      <= '0;
          prod     <= '0;
          mcand    <= (2*WIDTH)'(abs_a);
          qd       <= DW'(abs_a) << FRAC;
          rem      <= '0;
          in_ready <= 1'b0;
          state    <= is_mul ? MUL : (is_div ? DIV : DONE);
        end
        MUL: begin
          prod  <= prod_nx;
          mcand <= mcand << 1;
          mb    <= mb >> 1;
          cnt   <= cnt + 1'b1;
        end
        DIV: begin
          rem <= rem_nx;
          qd  <= qd_nx;
          cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        result    <= res_c;
        zero      <= (res_c == '0);
        ovf       <= ovf_c;
        div0      <= dz;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_fxp_alu_seq.sv
// tb_fxp_alu_seq: directed vector bench for fxp_alu_seq, Q20.12.
// Expectations follow FXP_SAT_EN when the bench is built with it.
module tb_fxp_alu_seq;

`ifdef FXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, ovf, div0;

  int checks = 0;
  int errors = 0;

  fxp_alu_seq #(.WIDTH(32), .FRAC(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rw;
    logic [31:0] rs;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready before issue", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [31:0] er;

    v[0]  = '{3'b000, 32'd847872, 32'd2048, 32'd849920, 32'd849920, 1'b0, 1'b0, 1};
    v[1]  = '{3'b001, 32'd847872, 32'd2048, 32'd845824, 32'd845824, 1'b0, 1'b0, 1};
    v[2]  = '{3'b010, 32'd847872, 32'd2048, 32'd423936, 32'd423936, 1'b0, 1'b0, 33};
    v[3]  = '{3'b011, 32'd847872, 32'd2048, 32'd1695744, 32'd1695744, 1'b0, 1'b0, 45};
    v[4]  = '{3'b011, -32'sd847872, 32'd2048, -32'sd1695744, -32'sd1695744, 1'b0, 1'b0, 45};
    v[5]  = '{3'b011, 32'd4096, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
    v[6]  = '{3'b011, -32'sd4096, 32'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1};
    v[7]  = '{3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h00F000F0, 1'b0, 1'b0, 1};
    v[8]  = '{3'b101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1};
    v[9]  = '{3'b110, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 1'b0, 1};
    v[10] = '{3'b111, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1};
    v[11] = '{3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    v[12] = '{3'b001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
    v[13] = '{3'b011, 32'h40000000, 32'd1, 32'h0, 32'h7FFFFFFF, 1'b1, 1'b0, 45};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", {zero, ovf, div0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_out(lat);
      er = SAT ? v[i].rs : v[i].rw;
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      chk($sformatf("v%0d result", i), result, er);
      chk($sformatf("v%0d ovf", i), ovf, v[i].ovf);
      chk($sformatf("v%0d div0", i), div0, v[i].dz);
      chk($sformatf("v%0d zero", i), zero, er == 32'h0);
      consume();
    end

    // mul overflow held under backpressure
    issue(3'b010, 32'h40000000, 32'h40000000);
    wait_out(lat);
    er = SAT ? 32'h7FFFFFFF : 32'h0;
    chk("bp latency", lat, 33);
    chk("bp ovf", ovf, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d result", k), result, er);
      chk($sformatf("bp hold%0d valid", k), out_valid, 1);
      chk($sformatf("bp hold%0d in_ready", k), in_ready, 0);
    end
    consume();
    chk("bp consumed valid", out_valid, 0);
    chk("bp consumed in_ready", in_ready, 1);

    // out_ready already high when the result appears
    out_ready = 1'b1;
    issue(3'b000, 32'd4096, 32'd8192);
    chk("early ready valid", out_valid, 1);
    chk("early ready result", result, 12288);
    @(posedge clk); #1;
    chk("early ready consumed", out_valid, 0);
    chk("early ready in_ready", in_ready, 1);
    out_ready = 1'b0;

    // reset in the middle of a divide
    issue(3'b011, 32'd847872, 32'd2048);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort no result", seen, 0);
    issue(3'b000, 32'd847872, 32'd2048);
    wait_out(lat);
    chk("post abort latency", lat, 1);
    chk("post abort result", result, 849920);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_alu_seq.md
Name: fxp_alu_seq

Overview:
- Parametrised, multi-cycle signed fixed-point ALU. Successor to the combinational fixed-point ALU; default format is Q20.12.
- Adds an iterative multiplier, an iterative divider, valid/ready handshakes and status flags.
- Sits between the ASIP register-file read stage and the writeback stage.
- Holds one operation in flight at a time.

Parameters:
- WIDTH, 32: operand and result width in bits, two's complement.
- FRAC, 12: number of fractional bits. Legal range is 0 to WIDTH-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 pass a.
- a  in  WIDTH  operand A, signed fixed-point.
- b  in  WIDTH  operand B, signed fixed-point.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result value.
- zero  out  1  result equals 0.
- ovf  out  1  result overflowed the format (add, sub, mul, div).
- div0  out  1  division by zero occurred.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, result=0, zero=0, ovf=0, div0=0.
  - Internal accumulator, counter and operand registers are cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- Handshake:
  - An operation is accepted on an edge where in_valid && in_ready. Operands and op are captured.
  - in_ready is high only in IDLE.
  - A result is consumed on an edge where out_valid && out_ready.
  - result and all flags hold stable while out_valid=1 && !out_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, accept of add/sub/logic/pass: result is computed and registered; go to DONE. out_valid=1 one edge after accept.
  - IDLE, accept of mul: go to MUL. out_valid=1 exactly WIDTH+1 edges after accept.
  - IDLE, accept of div with b!=0: go to DIV. out_valid=1 exactly WIDTH+FRAC+1 edges after accept.
  - IDLE, accept of div with b==0: go to DONE. out_valid=1 one edge after accept; div0=1.
  - MUL: unsigned shift-add on |a| and |b|, one bit per cycle, WIDTH iterations. On the last iteration, apply the sign (a[MSB]^b[MSB]), arithmetic-shift the 2*WIDTH product right by FRAC, go to DONE.
  - DIV: restoring division of (|a| << FRAC) by |b|, one quotient bit per cycle, WIDTH+FRAC iterations. Apply the sign, go to DONE. The quotient truncates toward zero.
  - DONE: out_valid=1. On consume, go to IDLE.
  - A new operation can be accepted no earlier than the edge after consume.
- Magnitudes use WIDTH+1 bits, so -2^(WIDTH-1) is handled exactly.
- Overflow rules:
  - add/sub: ovf = signed overflow of WIDTH-bit two's complement.
  - mul: ovf=1 if the shifted product does not fit in WIDTH signed bits.
  - div: ovf=1 if the quotient does not fit in WIDTH signed bits.
  - Logic ops and pass: ovf=0.
- Result on overflow: low WIDTH bits (wrap), unless FXP_SAT_EN is defined.
- div0 result: 2^(WIDTH-1)-1 if a>=0, else -2^(WIDTH-1). ovf=0.
- zero reflects the final registered result, after saturation if FXP_SAT_EN is defined.
- Flags are updated only when a new result is registered.
- Inputs while busy are ignored, since in_ready=0.
- When out_ready=1 in the same cycle that out_valid rises, the result is consumed on the next edge.

Optional Feature:
- Macro: FXP_SAT_EN.
- Defined: on ovf=1, result saturates to 2^(WIDTH-1)-1 for positive true results and -2^(WIDTH-1) for negative true results. ovf is still reported.
- Not defined: on ovf=1, result wraps to the low WIDTH bits of the true result.
- Latency is identical in both builds.

Test Plan:
- Add and sub, WIDTH=32, FRAC=12, a=847872 (207.0), b=2048 (0.5):
  - add -> result=849920 one edge after accept, ovf=0.
  - sub -> result=845824.
- mul, a=847872, b=2048 -> result=423936 (103.5), out_valid exactly 33 edges after accept, zero=0.
- div, a=847872, b=2048 -> result=1695744 (414.0), out_valid exactly 45 edges after accept.
- Same div with a=-847872 -> result=-1695744.
- div, b=0, a=4096 -> div0=1, result=0x7FFFFFFF one edge after accept.
- Overflow and backpressure: mul a=0x40000000, b=0x40000000 -> ovf=1.
  - With FXP_SAT_EN defined: result=0x7FFFFFFF.
  - Hold out_ready=0 for 5 cycles: result stable, in_ready=0. Then a single-cycle out_ready consumes the result.
- Reset mid-operation: pulse rst_n low 10 cycles into a div -> out_valid=0 and in_ready=1 immediately; no result is produced afterwards. A following add completes normally.
